gradient_outlet_scanner: RTL and testbench

GRADIENT_OUTLET_SCANNER -- requirements
Module: gradient_outlet_scanner

---
 rtl/gradient_outlet_scanner_if.sv | 25 ++
 rtl/gradient_outlet_scanner.sv | 149 ++++++++++++++
 tb/tb_gradient_outlet_scanner.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gradient_outlet_scanner_if.sv
// Detector-side bus for the gradient outlet scanner: mux select, ADC request/ack
// and the outgoing valid/ready sample stream.
interface gradient_outlet_scanner_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        sel;
    logic              adc_req;
    logic              adc_ack;
    logic [DATA_W-1:0] adc_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_chan;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output sel, adc_req, out_valid, out_chan, out_data, out_last,
        input  adc_ack, adc_data, out_ready
    );

    modport slave (
        input  sel, adc_req, out_valid, out_chan, out_data, out_last,
        output adc_ack, adc_data, out_ready
    );
endinterface

// File: rtl/gradient_outlet_scanner.sv
// Sweeps NUM_OUT gradient outlet detectors: settle the mux, convert one sample,
// emit it on a valid/ready stream, and count completed sweeps.
module gradient_outlet_scanner #(
    parameter int NUM_OUT    = 7,
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont,
    input  logic        stop,
    input  logic        abort,
    output logic        busy,
    output logic [15:0] sweep_cnt,
    output logic [1:0]  dbg_state,
    gradient_outlet_scanner_if.master bus
);

    // Stream handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low, the
    // channel, data and last flag stay frozen and out_valid is never withdrawn.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam logic [2:0] LAST_SEL    = 3'(NUM_OUT - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_t            state;
    state_t            state_n;
    logic [2:0]        sel_q;
    logic [7:0]        settle_cnt;
    logic [DATA_W-1:0] sample;
    logic              cont_q;
    logic              stop_pend;
    logic [15:0]       sweep_q;
    logic              last_chan;
    logic              stop_eff;

    assign last_chan = (sel_q == LAST_SEL);
    // A stop arriving in the final handshake cycle still ends the sweep.
    assign stop_eff  = stop_pend | stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_n = SETTLE;
                SETTLE:  if (settle_cnt == 8'd0) state_n = CONVERT;
                CONVERT: if (bus.adc_ack) state_n = EMIT;
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last_chan && !(cont_q && !stop_eff)) begin
                            state_n = IDLE;
                        end else begin
                            state_n = SETTLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        dbg_state     = state;
        sweep_cnt     = sweep_q;
        bus.sel       = sel_q;
        bus.adc_req   = (state == CONVERT);
        bus.out_valid = 1'b0;
        bus.out_chan  = 3'd0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        if (state == EMIT) begin
            bus.out_valid = 1'b1;
            bus.out_chan  = sel_q;
            bus.out_data  = sample;
            bus.out_last  = last_chan;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= 3'd0;
            settle_cnt <= 8'd0;
            sample     <= '0;
            cont_q     <= 1'b0;
            stop_pend  <= 1'b0;
            sweep_q    <= 16'd0;
        end else if (abort) begin
            sel_q <= 3'd0;
        end else begin
            if (state != IDLE && stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q      <= 3'd0;
                        cont_q     <= cont;
                        stop_pend  <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CONVERT: begin
                    if (bus.adc_ack) begin
                        sample <= bus.adc_data;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        settle_cnt <= SETTLE_LOAD;
                        if (last_chan) begin
                            sel_q <= 3'd0;
                            if (sweep_q != 16'hFFFF) begin
                                sweep_q <= sweep_q + 16'd1;
                            end
                        end else begin
                            sel_q <= sel_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gradient_outlet_scanner.sv
// Directed bench for gradient_outlet_scanner: single, stalled, continuous,
// aborted, disturbed, saturating and reset-interrupted sweeps.
module tb_gradient_outlet_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cont;
    logic        stop;
    logic        abort;
    logic        busy;
    logic [15:0] sweep_cnt;
    logic [1:0]  dbg_state;

    gradient_outlet_scanner_if #(.DATA_W(8)) bus();

    gradient_outlet_scanner #(.NUM_OUT(7), .DATA_W(8), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop),
        .abort(abort), .busy(busy), .sweep_cnt(sweep_cnt),
        .dbg_state(dbg_state), .bus(bus)
    );

    bit block_ch4 = 1'b0;
    bit spur      = 1'b0;
    bit hold_ch3  = 1'b0;

    // Immediate ADC returning 0x10+sel, with hooks to stall chan 4 or inject a stray ack.
    assign bus.adc_ack   = (bus.adc_req && !(block_ch4 && bus.sel == 3'd4)) || spur;
    assign bus.adc_data  = 8'h10 + {5'd0, bus.sel};
    assign bus.out_ready = !(hold_ch3 && bus.out_valid && bus.out_chan == 3'd3);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [2:0] q_chan[$];
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_chan.push_back(bus.out_chan);
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_sweeps = 16'd0;

    task automatic clear_beats();
        q_chan.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic pulse_start(input bit c, input bit s);
        @(posedge clk); #1;
        start = 1'b1; cont = c; stop = s;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (q_chan.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [17:0] bus_out;
        rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        bus_out = {bus.sel, bus.adc_req, bus.out_valid, bus.out_chan, bus.out_data, bus.out_last};
        n_checks++;
        if (bus_out !== 18'd0) $display("FAIL reset_bus got=%h exp=0", bus_out);
        else n_pass++;
        n_checks++;
        if ({busy, dbg_state} !== 3'd0) $display("FAIL reset_state got busy=%b state=%0d exp 0/0", busy, dbg_state);
        else n_pass++;
        n_checks++;
        if (sweep_cnt !== 16'd0) $display("FAIL reset_sweep_cnt got=%h exp=0", sweep_cnt);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        // stop while idle must not leak into the next sweep
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset got busy=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_single_sweep();
        bit ok;
        logic [11:0] got, exp;
        clear_beats();
        pulse_start(1'b0, 1'b0);
        wait_beats(7, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL single_timeout got=%0d beats exp=7", q_chan.size());
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", busy);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (q_chan.size() !== 7) $display("FAIL single_count got=%0d exp=7", q_chan.size());
        else n_pass++;
        for (int i = 0; i < 7 && i < q_chan.size(); i++) begin
            got = {q_chan[i], q_data[i], q_last[i]};
            exp = {3'(i), 8'(8'h10 + i), (i == 6)};
            n_checks++;
            if (got !== exp) $display("FAIL single_beat%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        for (int i = 1; i < 7 && i < q_cyc.size(); i++) begin
            n_checks++;
            if (q_cyc[i] - q_cyc[i-1] !== 6) $display("FAIL single_period%0d got=%0d exp=6", i, q_cyc[i] - q_cyc[i-1]);
            else n_pass++;
        end
        exp_sweeps = exp_sweeps + 16'd1;
        n_checks++;
        if (sweep_cnt !== exp_sweeps) $display("FAIL single_sweep_cnt got=%0d exp=%0d", sweep_cnt, exp_sweeps);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        logic [11:0] got, exp;
        clear_beats();
        hold_ch3 = 1'b1;
        pulse_start(1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bus.out_valid && bus.out_chan == 3'd3) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL stall_reach_ch3 got=%0d beats exp=3", q_chan.size());
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            got = {bus.out_valid, bus.adc_req, bus.out_chan, bus.out_data[6:0]};
            exp = {1'b1, 1'b0, 3'd3, 7'h13};
            n_checks++;
            if (got !== exp || bus.out_data !== 8'h13)
                $display("FAIL stall_hold%0d got=%h data=%h exp=%h data=13", i, got, bus.out_data, exp);
            else n_pass++;
            @(negedge clk); #1;
        end
        @(posedge clk); #1 hold_ch3 = 1'b0;
        wait_beats(7, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_timeout got=%0d beats exp=7", q_chan.size());
        else n_pass++;
        for (int i = 0; i < 7 && i < q_chan.size(); i++) begin
            got = {q_chan[i], q_data[i], q_last[i]};
            exp = {3'(i), 8'(8'h10 + i), (i == 6)};
            n_checks++;
            if (got !== exp) $display("FAIL stall_beat%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        exp_sweeps = exp_sweeps + 16'd1;
        n_checks++;
        if (sweep_cnt !== exp_sweeps) $display("FAIL stall_sweep_cnt got=%0d exp=%0d", sweep_cnt, exp_sweeps);
        else n_pass++;
    endtask

    task automatic test_continuous_stop();
        bit ok;
        logic [3:0] got, exp;
        clear_beats();
        // start together with stop: stop must not be latched
        pulse_start(1'b1, 1'b1);
        wait_beats(10, 300, ok);
        n_checks++;
        if (!ok) $display("FAIL cont_reach_s2c2 got=%0d beats exp=10", q_chan.size());
        else n_pass++;
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_beats(14, 300, ok);
        repeat (40) @(negedge clk);
        #1;
        n_checks++;
        if (q_chan.size() !== 14) $display("FAIL cont_count got=%0d exp=14", q_chan.size());
        else n_pass++;
        for (int i = 7; i < 14 && i < q_chan.size(); i++) begin
            got = {q_chan[i], q_last[i]};
            exp = {3'(i - 7), (i == 13)};
            n_checks++;
            if (got !== exp) $display("FAIL cont_beat%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        exp_sweeps = exp_sweeps + 16'd2;
        n_checks++;
        if ({busy, sweep_cnt} !== {1'b0, exp_sweeps}) $display("FAIL cont_end got busy=%b cnt=%0d exp 0/%0d", busy, sweep_cnt, exp_sweeps);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        logic [7:0] got;
        clear_beats();
        block_ch4 = 1'b1;
        pulse_start(1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bus.adc_req && bus.sel == 3'd4) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL abort_reach_ch4 got sel=%0d exp=4", bus.sel);
        else n_pass++;
        // ack in the abort cycle must lose to abort
        abort = 1'b1; spur = 1'b1;
        @(posedge clk); #1 abort = 1'b0; spur = 1'b0; block_ch4 = 1'b0;
        @(negedge clk); #1;
        got = {dbg_state, bus.adc_req, bus.out_valid, bus.sel, busy};
        n_checks++;
        if (got !== 8'd0) $display("FAIL abort_idle got=%h exp=00", got);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (q_chan.size() !== 4 || sweep_cnt !== exp_sweeps)
            $display("FAIL abort_no_count got beats=%0d cnt=%0d exp 4/%0d", q_chan.size(), sweep_cnt, exp_sweeps);
        else n_pass++;
        clear_beats();
        pulse_start(1'b0, 1'b0);
        wait_beats(7, 200, ok);
        repeat (3) @(negedge clk);
        exp_sweeps = exp_sweeps + 16'd1;
        n_checks++;
        if (!ok || q_chan[0] !== 3'd0 || q_data[6] !== 8'h16 || sweep_cnt !== exp_sweeps)
            $display("FAIL abort_restart got beats=%0d cnt=%0d exp 7/%0d", q_chan.size(), sweep_cnt, exp_sweeps);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        logic [11:0] got, exp;
        clear_beats();
        pulse_start(1'b0, 1'b0);
        wait_beats(1, 100, ok);
        @(posedge clk); #1;
        start = 1'b1; spur = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; spur = 1'b0;
        wait_beats(7, 200, ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (q_chan.size() !== 7) $display("FAIL busy_count got=%0d exp=7", q_chan.size());
        else n_pass++;
        for (int i = 0; i < 7 && i < q_chan.size(); i++) begin
            got = {q_chan[i], q_data[i], q_last[i]};
            exp = {3'(i), 8'(8'h10 + i), (i == 6)};
            n_checks++;
            if (got !== exp) $display("FAIL busy_beat%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        for (int i = 1; i < 7 && i < q_cyc.size(); i++) begin
            n_checks++;
            if (q_cyc[i] - q_cyc[i-1] !== 6) $display("FAIL busy_period%0d got=%0d exp=6", i, q_cyc[i] - q_cyc[i-1]);
            else n_pass++;
        end
        exp_sweeps = exp_sweeps + 16'd1;
        n_checks++;
        if ({busy, sweep_cnt} !== {1'b0, exp_sweeps}) $display("FAIL busy_end got busy=%b cnt=%0d exp 0/%0d", busy, sweep_cnt, exp_sweeps);
        else n_pass++;
    endtask

    task automatic test_saturation();
        bit ok;
        @(posedge clk); #1;
        force dut.sweep_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.sweep_q;
        @(negedge clk); #1;
        n_checks++;
        if (sweep_cnt !== 16'hFFFE) $display("FAIL sat_preload got=%h exp=fffe", sweep_cnt);
        else n_pass++;
        for (int s = 0; s < 2; s++) begin
            clear_beats();
            pulse_start(1'b0, 1'b0);
            wait_beats(7, 200, ok);
            repeat (3) @(negedge clk);
            n_checks++;
            if (!ok || sweep_cnt !== 16'hFFFF) $display("FAIL sat_sweep%0d got=%h exp=ffff", s, sweep_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        int n_at;
        logic [11:0] got, exp;
        clear_beats();
        pulse_start(1'b0, 1'b0);
        wait_beats(3, 100, ok);
        rst = 1'b1;
        #1;
        got = {dbg_state, busy, bus.adc_req, bus.out_valid, bus.sel, 4'd0};
        n_checks++;
        if (got !== 12'd0 || sweep_cnt !== 16'd0) $display("FAIL rst_async got=%h cnt=%h exp=0/0", got, sweep_cnt);
        else n_pass++;
        n_at = q_chan.size();
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (q_chan.size() !== n_at) $display("FAIL rst_no_beat got=%0d exp=%0d", q_chan.size(), n_at);
        else n_pass++;
        clear_beats();
        pulse_start(1'b0, 1'b0);
        wait_beats(7, 200, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7 && i < q_chan.size(); i++) begin
            got = {q_chan[i], q_data[i], q_last[i]};
            exp = {3'(i), 8'(8'h10 + i), (i == 6)};
            n_checks++;
            if (got !== exp) $display("FAIL rst_beat%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (!ok || sweep_cnt !== 16'd1) $display("FAIL rst_restart_cnt got=%0d exp=1", sweep_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_stall();
        test_continuous_stop();
        test_abort();
        test_start_while_busy();
        test_saturation();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
